// File: rtl/serial_adder_driver_if.sv
// Parallel-side handshake bundle for serial_adder_driver.
// Host drives start/operands; driver returns status and result.
interface serial_adder_driver_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   result;
    logic             chk_err;

    modport master (
        output start, op_a, op_b,
        input  busy, done, result, chk_err
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, result, chk_err
    );
endinterface

// File: rtl/serial_adder_driver.sv
// Parallel host for a bit-serial Moore adder: streams operands LSB-first.
// Optional self-check enabled by defining SERIAL_ADDER_DRIVER_CHK_EN.
module serial_adder_driver #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_driver_if.slave bus,
    output logic                 ser_clr,
    output logic                 ser_a,
    output logic                 ser_b,
    input  logic                 ser_sum
);
    localparam int CW = $clog2(WIDTH + 1) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH:0]   result_q;
    logic [WIDTH:0]   fin;

    // acc holds sum bits 0..WIDTH-1; the carry arrives last in DRAIN
    assign fin = {ser_sum, acc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ser_clr  <= 1'b1;
            ser_a    <= 1'b0;
            ser_b    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh    <= bus.op_a >> 1;
                        b_sh    <= bus.op_b >> 1;
                        ser_a   <= bus.op_a[0];
                        ser_b   <= bus.op_b[0];
                        acc     <= '0;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        ser_clr <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    // Moore latency: cycle cnt carries sum bit cnt-1
                    if (cnt != '0) begin
                        acc <= {ser_sum, acc[WIDTH-1:1]};
                    end
                    if (cnt == LAST) begin
                        ser_a <= 1'b0;
                        ser_b <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        ser_a <= a_sh[0];
                        ser_b <= b_sh[0];
                    end
                end
                DRAIN: begin
                    result_q <= fin;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    ser_clr  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

`ifdef SERIAL_ADDER_DRIVER_CHK_EN
    logic [WIDTH:0] ref_q;
    logic           chk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
            chk_q <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                ref_q <= {1'b0, bus.op_a} + {1'b0, bus.op_b};
            end
            if (state == DRAIN && ref_q != fin) begin
                chk_q <= 1'b1;
            end
        end
    end

    assign bus.chk_err = chk_q;
`else
    assign bus.chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder_driver.sv
// Scoreboard bench for serial_adder_driver with a behavioural Moore adder.
// Random and directed operations; expected sums from plain arithmetic.
module tb_serial_adder_driver;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    logic ser_clr;
    logic ser_a;
    logic ser_b;
    logic ser_sum;
    logic s_q;
    logic c_q;
    logic inj;

    serial_adder_driver_if #(.WIDTH(W)) bus ();

    serial_adder_driver #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .ser_clr (ser_clr),
        .ser_a   (ser_a),
        .ser_b   (ser_b),
        .ser_sum (ser_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Moore serial adder: sum and carry registered, sync clear
    always @(posedge clk) begin
        if (ser_clr) begin
            s_q <= 1'b0;
            c_q <= 1'b0;
        end else begin
            {c_q, s_q} <= 2'(ser_a) + 2'(ser_b) + 2'(c_q);
        end
    end
    assign ser_sum = s_q ^ inj;

    int n_chk = 0;
    int n_pass = 0;
    logic [W:0] exp_q[$];
    logic [W:0] last_res;
    logic prev_done;
    logic chk_exp;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // monitor: pops an expectation on every done pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            last_res  = '0;
            prev_done = 1'b0;
        end else begin
            if (bus.done) begin
                check("done_width", prev_done, 0);
                if (exp_q.size() == 0) begin
                    check("done_without_op", bus.done, 0);
                end else begin
                    check("result", bus.result, exp_q.pop_front());
                end
                last_res = bus.result;
            end else begin
                check("result_hold", bus.result, last_res);
            end
            prev_done = bus.done;
        end
    end

    task automatic wait_idle();
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!bus.busy && !bus.done) break;
        end
        check("idle_timeout", bus.busy | bus.done, 0);
        check("ser_clr_idle", ser_clr, 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit spur, input bit fault);
        logic [W:0] e;
        logic [W:0] sa;
        logic [W:0] sb;
        int n;
        int bcnt;
        bit clr_bad;
        e = {1'b0, a} + {1'b0, b};
        if (fault) e = e ^ (W+1)'(8);
        wait_idle();
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        bus.start = 1'b0;
        bus.op_a  = W'($urandom);
        bus.op_b  = W'($urandom);
        check("busy_after_accept", bus.busy, 1);
        sa = '0;
        sb = '0;
        sa[0] = ser_a;
        sb[0] = ser_b;
        bcnt = 1;
        clr_bad = ser_clr;
        for (n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            inj = fault && (n == 4);
            if (spur) begin
                bus.start = (n == 3);
                bus.op_a  = '1;
                bus.op_b  = '1;
            end
            if (bus.done) break;
            if (bus.busy) bcnt++;
            if (bus.busy && ser_clr) clr_bad = 1'b1;
            if (n <= W) begin
                sa[n] = ser_a;
                sb[n] = ser_b;
            end
        end
        bus.start = 1'b0;
        inj = 1'b0;
        check("latency", n, W + 2);
        check("busy_cycles", bcnt, W + 2);
        check("ser_a_stream", sa, {1'b0, a});
        check("ser_b_stream", sb, {1'b0, b});
        check("ser_clr_busy", clr_bad, 0);
        if (fault) chk_exp = 1'b1;
        @(posedge clk);
        #1;
        check("done_pulse", bus.done, 0);
        check("chk_err", bus.chk_err, chk_exp);
    endtask

    task automatic back_to_back();
        int t0;
        int t1;
        int t;
        wait_idle();
        bus.op_a  = 8'h10;
        bus.op_b  = 8'h20;
        bus.start = 1'b1;
        exp_q.push_back(9'h030);
        exp_q.push_back(9'h030);
        t0 = -1;
        t1 = -1;
        for (t = 0; t < 40; t++) begin
            @(posedge clk);
            #1;
            if (t == W + 4) bus.start = 1'b0;
            if (bus.done && t0 < 0) t0 = t;
            else if (bus.done) begin
                t1 = t;
                break;
            end
        end
        bus.start = 1'b0;
        check("b2b_first", t0, W + 2);
        check("b2b_gap", t1 - t0, W + 4);
    endtask

    task automatic mid_reset();
        wait_idle();
        bus.op_a  = 8'hAA;
        bus.op_b  = 8'h55;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_chk_err", bus.chk_err, 0);
        check("rst_ser_a", ser_a, 0);
        check("rst_ser_b", ser_b, 0);
        check("rst_ser_clr", ser_clr, 1);
        chk_exp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        inj       = 1'b0;
        chk_exp   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        check("reset_ser_clr", ser_clr, 1);
        check("reset_ser_ab", {ser_a, ser_b}, 0);
        check("reset_chk_err", bus.chk_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h3C, 0, 0);
        run_op(8'hFF, 8'hFF, 0, 0);
        run_op(8'h00, 8'h00, 0, 0);
        run_op(8'h12, 8'h34, 1, 0);
        back_to_back();
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 0, 0);
        end
`ifdef SERIAL_ADDER_DRIVER_CHK_EN
        run_op(8'h01, 8'h01, 0, 1);
        run_op(8'h07, 8'h09, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        check("chk_err_sticky", bus.chk_err, 1);
`endif
        mid_reset();
        run_op(8'h80, 8'h80, 0, 0);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("pending_ops", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
